fpu_writeback: RTL and testbench

//  Writeback stage directly downstream of the single-cycle FPU datapath.
//  - Captures one FPU result per handshake and formats it to XLEN: NaN-box, sign-extend or zero-extend by ftype.
//  - Holds results in a 2-entry FIFO and retires them to the FP or integer register file over a valid/ready port.
//  - Accumulates exception flags into the sticky fflags CSR field; the CSR unit can also write that field.

---
 rtl/fpu_writeback_if.sv | 34 +++
 rtl/fpu_writeback.sv | 127 ++++++++++++
 tb/tb_fpu_writeback.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_writeback_if.sv
// Handshake bundle between the FPU datapath, the writeback stage and the register files.
// The writeback stage uses the slave view; the environment driving it uses master.
interface fpu_writeback_if #(
  parameter int XLEN = 64,
  parameter int FLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_ftype;
  logic [4:0]      in_rd;
  logic [FLEN-1:0] in_farith;
  logic [31:0]     in_w_cvt;
  logic [63:0]     in_l_cvt;
  logic            in_cmp;
  logic [XLEN-1:0] in_class;
  logic [4:0]      in_flags;
  logic            wb_valid;
  logic            wb_ready;
  logic            wb_is_fp;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport slave (
    input  in_valid, in_ftype, in_rd, in_farith, in_w_cvt, in_l_cvt,
           in_cmp, in_class, in_flags, wb_ready,
    output in_ready, wb_valid, wb_is_fp, wb_rd, wb_data
  );

  modport master (
    output in_valid, in_ftype, in_rd, in_farith, in_w_cvt, in_l_cvt,
           in_cmp, in_class, in_flags, wb_ready,
    input  in_ready, wb_valid, wb_is_fp, wb_rd, wb_data
  );
endinterface

// File: rtl/fpu_writeback.sv
// FPU writeback stage: formats results to XLEN, buffers them in a 2-entry FIFO
// and retires them to the register files while accruing sticky fflags.
module fpu_writeback #(
  parameter int XLEN     = 64,
  parameter int EXPWIDTH = 8,
  parameter int SIGWIDTH = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  fpu_writeback_if.slave io,
  input  logic       csr_we,
  input  logic [4:0] csr_wdata,
  output logic [4:0] fflags,
  output logic       illegal_ftype
);
  localparam int FLEN = EXPWIDTH + SIGWIDTH;

  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] data_q  [2];
  logic [XLEN-1:0] data_d  [2];
  logic            is_fp_q [2];
  logic            is_fp_d [2];
  logic [4:0]      rd_q    [2];
  logic [4:0]      rd_d    [2];
  logic [4:0]      flags_q [2];
  logic [4:0]      flags_d [2];
  logic [4:0]      fflags_q, fflags_d;
  logic            illegal_q, illegal_d;

  logic            accept, retire, legal, enq, deq;
  logic            fmt_fp;
  logic [XLEN-1:0] fmt_data;
  logic [4:0]      retire_flags;

  always_comb begin
    fmt_fp   = 1'b0;
    fmt_data = '0;
    case (io.in_ftype)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
      5'd13, 5'd14, 5'd15, 5'd16, 5'd17: begin
        fmt_fp   = 1'b1;
        fmt_data = {{(XLEN-FLEN){1'b1}}, io.in_farith};
      end
      // fcvt.wu is sign-extended as well, matching RV64 convention
      5'd9, 5'd10:         fmt_data = {{(XLEN-32){io.in_w_cvt[31]}}, io.in_w_cvt};
      5'd11, 5'd12:        fmt_data = io.in_l_cvt;
      5'd18, 5'd19, 5'd20: fmt_data = {{(XLEN-1){1'b0}}, io.in_cmp};
      5'd21:               fmt_data = io.in_class;
      default: begin
        fmt_fp   = 1'b0;
        fmt_data = '0;
      end
    endcase
  end

  always_comb begin
    accept   = io.in_valid & io.in_ready;
    retire   = io.wb_valid & io.wb_ready;
    legal    = io.in_ftype <= 5'd21;
    enq      = accept & legal & ~flush;
    deq      = retire & ~flush;

    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    is_fp_d  = is_fp_q;
    rd_d     = rd_q;
    flags_d  = flags_q;

    if (flush) begin
      count_d  = '0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (enq) begin
        data_d[wr_ptr_q]  = fmt_data;
        is_fp_d[wr_ptr_q] = fmt_fp;
        rd_d[wr_ptr_q]    = io.in_rd;
        flags_d[wr_ptr_q] = io.in_flags;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (deq) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, enq} - {1'b0, deq};
    end

    // Flags of an entry retiring alongside a CSR write are merged, never dropped
    retire_flags = deq ? flags_q[rd_ptr_q] : '0;
    fflags_d     = csr_we ? (csr_wdata | retire_flags) : (fflags_q | retire_flags);
    illegal_d    = accept & ~legal & ~flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      data_q    <= '{default: '0};
      is_fp_q   <= '{default: 1'b0};
      rd_q      <= '{default: '0};
      flags_q   <= '{default: '0};
      fflags_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      data_q    <= data_d;
      is_fp_q   <= is_fp_d;
      rd_q      <= rd_d;
      flags_q   <= flags_d;
      fflags_q  <= fflags_d;
      illegal_q <= illegal_d;
    end
  end

  assign io.in_ready    = (count_q != 2'd2);
  assign io.wb_valid    = (count_q != 2'd0);
  assign io.wb_is_fp    = is_fp_q[rd_ptr_q];
  assign io.wb_rd       = rd_q[rd_ptr_q];
  assign io.wb_data     = data_q[rd_ptr_q];
  assign fflags         = fflags_q;
  assign illegal_ftype  = illegal_q;
endmodule

// File: tb/tb_fpu_writeback.sv
// Directed self-checking bench for fpu_writeback: formatting, FIFO ordering,
// backpressure, fflags accrual with CSR writes, flush, illegal ftype and reset.
module tb_fpu_writeback;
  logic       clk;
  logic       rst;
  logic       flush;
  logic       csr_we;
  logic [4:0] csr_wdata;
  logic [4:0] fflags;
  logic       illegal_ftype;

  int n_cmp;
  int n_err;

  fpu_writeback_if #(.XLEN(64), .FLEN(32)) bus ();

  fpu_writeback #(.XLEN(64), .EXPWIDTH(8), .SIGWIDTH(24)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .io            (bus.slave),
    .csr_we        (csr_we),
    .csr_wdata     (csr_wdata),
    .fflags        (fflags),
    .illegal_ftype (illegal_ftype)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled at the same point
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.in_valid  = 1'b0;
    bus.in_ftype  = '0;
    bus.in_rd     = '0;
    bus.in_farith = '0;
    bus.in_w_cvt  = '0;
    bus.in_l_cvt  = '0;
    bus.in_cmp    = 1'b0;
    bus.in_class  = '0;
    bus.in_flags  = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; flush = 1'b0; csr_we = 1'b0; csr_wdata = '0;
    clear_in();
    bus.wb_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    check_eq("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_wb_data",  bus.wb_data, 64'd0);
    check_eq("rst_wb_is_fp", 64'(bus.wb_is_fp), 64'd0);
    check_eq("rst_wb_rd",    64'(bus.wb_rd), 64'd0);
    check_eq("rst_fflags",   64'(fflags), 64'd0);
    check_eq("rst_illegal",  64'(illegal_ftype), 64'd0);

    // single-precision NaN-boxing
    bus.in_valid = 1'b1; bus.in_ftype = 5'd0; bus.in_farith = 32'h3F80_0000; bus.in_rd = 5'd3;
    step();
    clear_in();
    check_eq("fp_valid", 64'(bus.wb_valid), 64'd1);
    check_eq("fp_is_fp", 64'(bus.wb_is_fp), 64'd1);
    check_eq("fp_data",  bus.wb_data, 64'hFFFF_FFFF_3F80_0000);
    check_eq("fp_rd",    64'(bus.wb_rd), 64'd3);
    bus.wb_ready = 1'b1;
    step();
    bus.wb_ready = 1'b0;
    check_eq("fp_retired", 64'(bus.wb_valid), 64'd0);

    // fcvt.w sign extension and flag accrual on retire
    bus.in_valid = 1'b1; bus.in_ftype = 5'd9; bus.in_w_cvt = 32'h8000_0000;
    bus.in_flags = 5'b10000; bus.in_rd = 5'd5;
    step();
    clear_in();
    check_eq("w_data",  bus.wb_data, 64'hFFFF_FFFF_8000_0000);
    check_eq("w_is_fp", 64'(bus.wb_is_fp), 64'd0);
    check_eq("w_no_flags_before_retire", 64'(fflags), 64'd0);
    bus.wb_ready = 1'b1;
    step();
    bus.wb_ready = 1'b0;
    check_eq("w_fflags", 64'(fflags), 64'b10000);
    check_eq("w_retired", 64'(bus.wb_valid), 64'd0);

    // CSR write merged with simultaneous retire
    csr_we = 1'b1; csr_wdata = 5'b00001;
    step();
    csr_we = 1'b0;
    check_eq("csr_write", 64'(fflags), 64'b00001);
    bus.in_valid = 1'b1; bus.in_ftype = 5'd11; bus.in_l_cvt = 64'h1234_5678_9ABC_DEF0;
    bus.in_flags = 5'b00100; bus.in_rd = 5'd7;
    step();
    clear_in();
    check_eq("l_data", bus.wb_data, 64'h1234_5678_9ABC_DEF0);
    csr_we = 1'b1; csr_wdata = 5'b00000; bus.wb_ready = 1'b1;
    step();
    csr_we = 1'b0; bus.wb_ready = 1'b0;
    check_eq("csr_plus_retire", 64'(fflags), 64'b00100);

    // backpressure and FIFO ordering: A, B fill, C waits
    bus.in_valid = 1'b1; bus.in_ftype = 5'd18; bus.in_cmp = 1'b1; bus.in_rd = 5'd1;
    step();
    check_eq("fifo_ready_after_a", 64'(bus.in_ready), 64'd1);
    clear_in();
    bus.in_valid = 1'b1; bus.in_ftype = 5'd21; bus.in_class = 64'hDEAD; bus.in_rd = 5'd2;
    step();
    check_eq("fifo_full", 64'(bus.in_ready), 64'd0);
    check_eq("fifo_head_a", bus.wb_data, 64'd1);
    clear_in();
    bus.in_valid = 1'b1; bus.in_ftype = 5'd10; bus.in_w_cvt = 32'hFFFF_FFFE; bus.in_rd = 5'd4;
    step();
    check_eq("fifo_still_full", 64'(bus.in_ready), 64'd0);
    check_eq("fifo_stable_data", bus.wb_data, 64'd1);
    check_eq("fifo_stable_rd",   64'(bus.wb_rd), 64'd1);
    bus.wb_ready = 1'b1;
    step();
    check_eq("fifo_head_b_rd",   64'(bus.wb_rd), 64'd2);
    check_eq("fifo_head_b_data", bus.wb_data, 64'hDEAD);
    check_eq("fifo_ready_again", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    check_eq("fifo_head_c_valid", 64'(bus.wb_valid), 64'd1);
    check_eq("fifo_head_c_rd",    64'(bus.wb_rd), 64'd4);
    check_eq("fifo_head_c_data",  bus.wb_data, 64'hFFFF_FFFF_FFFF_FFFE);
    check_eq("fifo_head_c_is_fp", 64'(bus.wb_is_fp), 64'd0);
    step();
    bus.wb_ready = 1'b0;
    clear_in();
    check_eq("fifo_drained", 64'(bus.wb_valid), 64'd0);
    check_eq("fifo_fflags",  64'(fflags), 64'b00100);

    // flush of a full FIFO with concurrent accept and retire attempts
    bus.in_valid = 1'b1; bus.in_ftype = 5'd13; bus.in_farith = 32'h4000_0000;
    bus.in_flags = 5'b11111; bus.in_rd = 5'd8;
    step(); step();
    check_eq("flush_pre_full", 64'(bus.in_ready), 64'd0);
    flush = 1'b1; bus.wb_ready = 1'b1;
    step();
    flush = 1'b0; bus.wb_ready = 1'b0;
    clear_in();
    check_eq("flush_wb_valid", 64'(bus.wb_valid), 64'd0);
    check_eq("flush_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("flush_fflags",   64'(fflags), 64'b00100);

    // illegal ftype: pulse only, no enqueue, no flags
    bus.in_valid = 1'b1; bus.in_ftype = 5'd25; bus.in_flags = 5'b11111; bus.in_rd = 5'd6;
    step();
    clear_in();
    check_eq("illegal_pulse",    64'(illegal_ftype), 64'd1);
    check_eq("illegal_no_entry", 64'(bus.wb_valid), 64'd0);
    step();
    check_eq("illegal_pulse_end", 64'(illegal_ftype), 64'd0);
    check_eq("illegal_fflags",    64'(fflags), 64'b00100);

    // reset while an entry is retiring: entry and its flags are lost
    bus.in_valid = 1'b1; bus.in_ftype = 5'd0; bus.in_farith = 32'h1234_5678;
    bus.in_flags = 5'b01000; bus.in_rd = 5'd9;
    step();
    clear_in();
    check_eq("midrst_pre_valid", 64'(bus.wb_valid), 64'd1);
    rst = 1'b1; bus.wb_ready = 1'b1;
    step();
    rst = 1'b0; bus.wb_ready = 1'b0;
    check_eq("midrst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check_eq("midrst_fflags",   64'(fflags), 64'd0);
    check_eq("midrst_wb_data",  bus.wb_data, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
